// File: rtl/sd_clk_div_if.sv
// Host-side control and card-clock outputs of the SD clock divider.
// The divider takes the slave view; the host front end (or a bench) takes the master view.
interface sd_clk_div_if #(
  parameter int DIV_W = 10
);
  logic             pll_lock;
  logic             en;
  logic [DIV_W-1:0] div;
  logic             div_load;
  logic             clk_out;
  logic             rise_stb;
  logic             fall_stb;
  logic             ready;
  logic             stopped;

  modport master (
    output pll_lock, en, div, div_load,
    input  clk_out, rise_stb, fall_stb, ready, stopped
  );

  modport slave (
    input  pll_lock, en, div, div_load,
    output clk_out, rise_stb, fall_stb, ready, stopped
  );
endinterface

// File: rtl/sd_clk_div.sv
// Runtime-programmable SD card clock divider with glitch-free divisor switching,
// run/stop gating, PLL-lock qualification and edge strobes for the SD engines.
module sd_clk_div #(
  parameter int DIV_W       = 10,
  parameter int INIT_DIV    = 124,
  parameter int LOCK_CYCLES = 16
) (
  input logic        clkin,
  input logic        reset,
  sd_clk_div_if.slave bus
);
  localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] INIT_N = (INIT_DIV < 2) ? DIV_W'(2) : DIV_W'(INIT_DIV);

  typedef enum logic [1:0] {WAIT_LOCK, IDLE, RUN} state_t;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  // One extra bit so ceil(N/2) stays correct for the largest divisor.
  function automatic logic [DIV_W-1:0] half_up(input logic [DIV_W-1:0] n);
    logic [DIV_W:0] s;
    s = {1'b0, n} + (DIV_W+1)'(1);
    return s[DIV_W:1];
  endfunction

  logic              lock_s1, lock_s2;
  logic [LCNT_W-1:0] lock_cnt;
  logic              ready_r, ready_d;
  state_t            state;
  logic [DIV_W-1:0]  n_act, n_pend, pcnt, pcnt_nx, half;
  logic              last;
  logic              clk_r, rise_r, fall_r, stop_r;

  // ready_d is the value ready takes at the coming edge; the FSM acts on it so that
  // clk_out is parked in the same cycle ready drops.
  assign ready_d = lock_s1 && lock_s2 && (lock_cnt >= LCNT_W'(LOCK_CYCLES - 1));
  assign pcnt_nx = pcnt + DIV_W'(1);
  assign half    = half_up(n_act);
  assign last    = (pcnt == n_act - DIV_W'(1));

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_s1  <= 1'b0;
      lock_s2  <= 1'b0;
      lock_cnt <= '0;
      ready_r  <= 1'b0;
    end else begin
      lock_s1 <= bus.pll_lock;
      lock_s2 <= lock_s1;
      if (!lock_s2)
        lock_cnt <= '0;
      else if (lock_cnt != LCNT_W'(LOCK_CYCLES))
        lock_cnt <= lock_cnt + LCNT_W'(1);
      ready_r <= ready_d;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset)
      n_pend <= INIT_N;
    else if (bus.div_load)
      n_pend <= clamp_div(bus.div);
  end

  // Active divisor only changes at a period start, so a period never mixes two N.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state  <= WAIT_LOCK;
      n_act  <= INIT_N;
      pcnt   <= '0;
      clk_r  <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      stop_r <= 1'b1;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (!ready_d) begin
        state  <= WAIT_LOCK;
        pcnt   <= '0;
        clk_r  <= 1'b0;
        fall_r <= clk_r;
        stop_r <= 1'b1;
      end else begin
        case (state)
          WAIT_LOCK: state <= IDLE;
          IDLE: begin
            if (bus.en) begin
              state  <= RUN;
              n_act  <= n_pend;
              pcnt   <= '0;
              clk_r  <= 1'b1;
              rise_r <= 1'b1;
              stop_r <= 1'b0;
            end
          end
          RUN: begin
            if (last) begin
              pcnt <= '0;
              if (bus.en) begin
                n_act  <= n_pend;
                clk_r  <= 1'b1;
                rise_r <= 1'b1;
              end else begin
                state  <= IDLE;
                stop_r <= 1'b1;
              end
            end else begin
              pcnt   <= pcnt_nx;
              clk_r  <= (pcnt_nx < half);
              fall_r <= (pcnt_nx == half);
            end
          end
          default: state <= WAIT_LOCK;
        endcase
      end
    end
  end

  assign bus.clk_out  = clk_r;
  assign bus.rise_stb = rise_r;
  assign bus.fall_stb = fall_r;
  assign bus.ready    = ready_r;
  assign bus.stopped  = stop_r;
endmodule

// File: tb/tb_sd_clk_div.sv
// Bench for sd_clk_div: table of divisor/period-shape vectors, hand-written
// lock/gating/switch sequences, and a randomized run against a period-level model.
module tb_sd_clk_div;
  localparam int DIV_W       = 10;
  localparam int LOCK_CYCLES = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_clk_div_if #(.DIV_W(DIV_W)) bus ();

  sd_clk_div #(
    .DIV_W      (DIV_W),
    .INIT_DIV   (124),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clkin(clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int div;
    int hi;
    int lo;
  } vec_t;
  vec_t tbl[8];

  // Period-level reference: start time and length of the current period.
  int m_start, m_n, m_pend;
  bit m_run;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_rise(input string nm);
    int found;
    found = 0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (bus.rise_stb) begin
        found = 1;
        break;
      end
    end
    check(nm, found, 1);
  endtask

  task automatic load(input int d);
    bus.div      = DIV_W'(d);
    bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
  endtask

  // Called on the cycle a rise is observed; walks to the next rise.
  task automatic meas(output int hi, output int lo, output int nf);
    hi = 0;
    lo = 0;
    nf = 0;
    do begin
      if (bus.clk_out) hi++;
      else lo++;
      if (bus.fall_stb) nf++;
      tick();
    end while (!bus.rise_stb && (hi + lo) < 2000);
  endtask

  task automatic model_edge(input int k, input bit e, input bit ld, input int d);
    bit at_end;
    at_end = m_run && (k == m_start + m_n);
    if ((!m_run && e) || (at_end && e)) begin
      m_start = k;
      m_n     = m_pend;
      m_run   = 1'b1;
    end else if (at_end) begin
      m_run = 1'b0;
    end
    if (ld) m_pend = (d < 2) ? 2 : d;
  endtask

  initial begin
    int hi, lo, nf, n, t0, t1, t2, bad, nr_ready, nr_rise;
    bit e, ld;
    int d, ph, h;
    logic [3:0] ex;

    tbl[0] = '{div: 5,    hi: 3,   lo: 2};
    tbl[1] = '{div: 0,    hi: 1,   lo: 1};
    tbl[2] = '{div: 1,    hi: 1,   lo: 1};
    tbl[3] = '{div: 2,    hi: 1,   lo: 1};
    tbl[4] = '{div: 7,    hi: 4,   lo: 3};
    tbl[5] = '{div: 8,    hi: 4,   lo: 4};
    tbl[6] = '{div: 3,    hi: 2,   lo: 1};
    tbl[7] = '{div: 1023, hi: 512, lo: 511};

    reset        = 1'b1;
    bus.pll_lock = 1'b0;
    bus.en       = 1'b0;
    bus.div      = '0;
    bus.div_load = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {bus.clk_out, bus.rise_stb, bus.fall_stb, bus.ready, bus.stopped}, 5'b00001);
    reset = 1'b0;
    tick();
    check("rst_wait_lock", {bus.clk_out, bus.ready, bus.stopped}, 3'b001);

    // Lock with a one-cycle glitch: only the final rise counts.
    bad = 0;
    bus.pll_lock = 1'b1;
    repeat (10) begin
      tick();
      if (bus.ready) bad++;
    end
    bus.pll_lock = 1'b0;
    tick();
    if (bus.ready) bad++;
    bus.pll_lock = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (bus.clk_out || !bus.stopped) bad++;
    end while (!bus.ready && n < 100);
    check("lock_glitch_park", bad, 0);
    check("lock_latency", n, 2 + LOCK_CYCLES);

    // Default divisor and start latency.
    bus.en = 1'b1;
    tick();
    check("start_latency", {bus.clk_out, bus.rise_stb, bus.stopped}, 3'b110);
    meas(hi, lo, nf);
    check("def_hi", hi, 62);
    check("def_lo", lo, 62);
    check("def_fall_cnt", nf, 1);

    for (int i = 0; i < 8; i++) begin
      load(tbl[i].div);
      wait_rise($sformatf("tbl%0d_start", i));
      meas(hi, lo, nf);
      check($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
      check($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
      check($sformatf("tbl%0d_fall", i), nf, 1);
    end

    // Glitch-free switch: load mid-period, the running period keeps its length.
    load(124);
    wait_rise("sw_start");
    t0 = cyc;
    repeat (9) tick();
    load(4);
    wait_rise("sw_a");
    t1 = cyc;
    wait_rise("sw_b");
    t2 = cyc;
    check("sw_old_period", t1 - t0, 124);
    check("sw_new_period", t2 - t1, 4);

    // Gating: en drops in the high phase of an N=8 period.
    load(8);
    wait_rise("gate_start");
    bus.en = 1'b0;
    hi = 0;
    n  = 0;
    do begin
      if (bus.clk_out) hi++;
      tick();
      n++;
    end while (!bus.stopped && n < 50);
    check("gate_len", n, 8);
    check("gate_hi", hi, 4);
    check("gate_parked", {bus.clk_out, bus.rise_stb, bus.fall_stb}, 3'b000);

    bus.en = 1'b1;
    tick();
    check("idle_restart", {bus.rise_stb, bus.stopped}, 2'b10);
    t0 = cyc;
    bus.en = 1'b0;
    repeat (5) tick();
    bus.en = 1'b1;
    wait_rise("regate");
    check("regate_gap", cyc - t0, 8);

    // Lock loss during the high phase.
    wait_rise("loss_start");
    bus.pll_lock = 1'b0;
    tick();
    check("loss_hold", {bus.ready, bus.clk_out}, 2'b11);
    tick();
    check("loss_park", {bus.ready, bus.clk_out, bus.fall_stb, bus.stopped}, 4'b0011);
    bus.pll_lock = 1'b1;
    nr_ready = 0;
    nr_rise  = 0;
    bad      = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.ready && nr_ready == 0) nr_ready = i;
      if (bus.rise_stb) begin
        nr_rise = i;
        break;
      end
      if (bus.clk_out) bad++;
    end
    check("relock_ready", nr_ready, 2 + LOCK_CYCLES);
    check("relock_rise", nr_rise, 3 + LOCK_CYCLES);
    check("relock_park", bad, 0);

    // Reset in the middle of a high phase.
    wait_rise("rst_mid_start");
    tick();
    reset = 1'b1;
    tick();
    check("rst_mid", {bus.clk_out, bus.rise_stb, bus.fall_stb, bus.stopped, bus.ready}, 5'b00010);
    reset  = 1'b0;
    bus.en = 1'b0;

    // Randomized run against the period-level model.
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.ready && n < 100);
    check("rand_ready", bus.ready, 1);
    m_run  = 1'b0;
    m_pend = 124;
    m_start = 0;
    m_n    = 124;
    for (int i = 0; i < 1500; i++) begin
      e  = ($urandom_range(9) != 0);
      ld = ($urandom_range(7) == 0);
      d  = $urandom_range(12);
      bus.en       = e;
      bus.div_load = ld;
      bus.div      = DIV_W'(d);
      model_edge(cyc + 1, e, ld, d);
      tick();
      if (m_run) begin
        ph = cyc - m_start;
        h  = (m_n + 1) / 2;
        ex = {ph < h, ph == 0, ph == h, 1'b0};
      end else begin
        ex = 4'b0001;
      end
      check($sformatf("rand_%0d", i), {bus.clk_out, bus.rise_stb, bus.fall_stb, bus.stopped}, ex);
    end
    bus.div_load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sd_clk_div.md
# sd_clk_div

Parametrised, runtime-programmable clock divider that derives the SD card clock from the PLL output clock. It extends the fixed-ratio divided PLL output with:
- a programmable divisor,
- glitch-free divisor switching,
- clock stop/start gating,
- PLL-lock qualification,
- edge strobes for the SD command/data engines.

It sits between the PLL output and the SD host front end. It drives the card clock pin and the sampling strobes.

## Interface
Parameters:
- DIV_W, 10: width of divisor input and period counter.
- INIT_DIV, 124: divisor loaded at reset (identification-mode clock).
- LOCK_CYCLES, 16: consecutive synchronised-lock cycles required before ready.

Ports:
- clkin  in  1  sole clock (PLL output domain).
- reset  in  1  synchronous, active-high reset.
- pll_lock  in  1  PLL lock, asynchronous; double-flop synchronised internally.
- en  in  1  run request for clk_out.
- div  in  DIV_W  requested period in clkin cycles.
- div_load  in  1  one-cycle strobe that captures div.
- clk_out  out  1  divided clock, registered.
- rise_stb  out  1  high in the cycle clk_out becomes 1.
- fall_stb  out  1  high in the cycle clk_out becomes 0.
- ready  out  1  PLL lock qualified.
- stopped  out  1  clk_out parked low, no period in progress.

## Operation
- Divisor handling:
  - Effective divisor N = max(div, 2) at capture; 0 and 1 clamp to 2.
  - div_load writes a pending register.
  - Pending is copied to the active divisor only at a period start, so the current period always completes with its old N and there are no runt pulses.
- Period shape: H = ceil(N/2) cycles high, then N−H cycles low; counter runs 0..N−1 and wraps.
- Lock qualifier:
  - After the 2-flop synchroniser, a counter increments while lock is high and clears on any low sample.
  - ready rises when the counter reaches LOCK_CYCLES.
  - ready falls in the first cycle the synchronised lock is low.
- States:
  - WAIT_LOCK: clk_out=0, stopped=1. Go to IDLE when ready.
  - IDLE: clk_out=0, stopped=1. When en=1, start a period next cycle → RUN.
  - RUN: generate periods. At the end of the last low cycle, go to IDLE if en=0, otherwise start the next period.
  - Loss of ready in any state → WAIT_LOCK immediately. clk_out is forced 0 that cycle, the counter is cleared, and fall_stb pulses if clk_out was 1.
- Reset state:
  - State WAIT_LOCK; clk_out, rise_stb, fall_stb, ready all 0; stopped=1.
  - Active and pending divisor = INIT_DIV (clamped); lock counter 0.
- en=0 mid-period: the period finishes in full (high and low phases) before parking. If en returns to 1 before the period ends, the next period follows seamlessly with no gap.
- Simultaneous div_load and period start in the same cycle: the new value applies to the period beginning the cycle after the next start. Pending capture has priority over the copy-to-active only in ordering; the copy uses the pre-load pending value.
- Reset mid-operation: all of the above reset values apply on the next edge, including mid-high-phase (clk_out drops, no fall_stb).

## Timing
- Start latency:
  - en sampled 1 in IDLE at cycle t → clk_out=1 and rise_stb=1 at t+1, stopped=0 at t+1.
  - Lock latency: pll_lock rising is seen after 2 sync cycles; ready asserts LOCK_CYCLES cycles later.
- Strobe alignment:
  - rise_stb and fall_stb are single-cycle pulses, coincident with the registered clk_out transition.
  - At most one strobe is high per cycle.
- Stop: stopped=1 in the first cycle after the final low cycle of the last period.
- Steady state: rising edges exactly N clkin cycles apart; fall_stb H cycles after rise_stb.
- div_load latency: takes effect at the first period start strictly after the load cycle.

## Test plan
- Reset defaults and lock qualification:
  - Assert reset, then pll_lock high 10 cycles, low 1, high → ready stays 0 through the glitch.
  - ready rises 2+16 cycles after the final rise of pll_lock; clk_out=0, stopped=1 throughout.
- Default divisor:
  - ready=1, en=1 → clk_out period 124 cycles, high 62, low 62.
  - rise_stb and fall_stb each pulse once per period at the clk_out edges.
- Odd divisor and clamp:
  - div=5 with div_load → high 3, low 2.
  - div=0 and div=1 → period 2 (1 high, 1 low).
- Glitch-free switch:
  - div_load div=4 in the 10th cycle of a 124-cycle period → that period still measures 124.
  - The next period measures 4.
- Gating:
  - en drops during the high phase of an N=8 period → the full 4 high + 4 low cycles complete, then stopped=1.
  - en reasserted 2 cycles before the period end → no gap, the next rise follows exactly 8 cycles later.
- Lock loss mid-run:
  - pll_lock drops during the high phase → after 2 sync cycles, ready=0, clk_out=0, fall_stb=1 in the same cycle.
  - Relock → clk_out restarts only after LOCK_CYCLES+2.
